// File: rtl/trace_capture_buffer.sv
// Trace recorder: captures trace words into a FWFT FIFO, stops on trap + post window or watchdog.
// Optional per-entry timestamps: define TRACE_CAPTURE_TIMESTAMP_EN.
module trace_capture_buffer #(
  parameter int DATA_W     = 36,
  parameter int DEPTH_LOG2 = 10,
  parameter int TS_W       = 32,
  parameter int POST_TRIG  = 10,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   arm_i,
  input  logic                   trace_valid_i,
  input  logic [DATA_W-1:0]      trace_data_i,
  input  logic                   trap_i,
  input  logic                   rd_ready_i,
  output logic                   rd_valid_o,
  output logic [TS_W+DATA_W-1:0] rd_data_o,
  output logic [1:0]             state_o,
  output logic [DEPTH_LOG2:0]    level_o,
  output logic                   overflow_o,
  output logic                   timeout_o,
  output logic [TS_W-1:0]        cycle_cnt_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam logic [PW-1:0]         POST_LOAD = PW'(POST_TRIG);
  localparam logic [TS_W-1:0]       TO_LAST   = TS_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic                  WD_EN     = (TIMEOUT != 0);
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  localparam int MEM_W = TS_W + DATA_W;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          post_cnt_q;
  logic [TS_W-1:0]        cnt_q;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]    level_q;
  logic                   ovf_q, to_q;
  logic [MEM_W-1:0]       mem [DEPTH];
  logic [MEM_W-1:0]       wr_word, head;
  logic                   running, capture, full, push, pop, timeout_hit;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
    return (v == '1) ? v : v + TS_W'(1);
  endfunction

  always_comb begin
    running     = (state_q == ARMED) || (state_q == POST);
    capture     = trace_valid_i && !arm_i &&
                  ((state_q == ARMED) || ((state_q == POST) && (post_cnt_q != '0)));
    full        = (level_q == FULL_LVL);
    push        = capture && !full;
    pop         = (level_q != '0) && rd_ready_i;
    timeout_hit = WD_EN && (state_q == ARMED) && !trap_i && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (trap_i) state_d = POST;
               else if (timeout_hit) state_d = DONE;
      POST:    if (post_cnt_q == '0) state_d = DONE;
      default: state_d = state_q;
    endcase
    // Re-arming restarts capture from any state.
    if (arm_i) state_d = ARMED;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      post_cnt_q <= POST_LOAD;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm_i) begin
        post_cnt_q <= POST_LOAD;
        cnt_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        ovf_q      <= 1'b0;
        to_q       <= 1'b0;
      end else begin
        if (running) cnt_q <= sat_inc(cnt_q);
        if ((state_q == POST) && (post_cnt_q != '0)) post_cnt_q <= post_cnt_q - PW'(1);
        if (timeout_hit) to_q <= 1'b1;
        // Fullness uses the pre-cycle level: a same-cycle pop never makes room.
        if (capture && full) ovf_q <= 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
          2'b10:   level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
          2'b01:   level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
          default: level_q <= level_q;
        endcase
      end
    end
  end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  assign wr_word = {cnt_q, trace_data_i};
`else
  assign wr_word = trace_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

  assign head = mem[rd_ptr_q];

  // Storage is never reset, so the read port is forced to zero while empty.
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  assign rd_data_o = (level_q != '0) ? head : '0;
`else
  assign rd_data_o = (level_q != '0) ? {{TS_W{1'b0}}, head} : '0;
`endif

  assign rd_valid_o  = (level_q != '0);
  assign state_o     = state_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign timeout_o   = to_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Randomised scoreboard bench for trace_capture_buffer against a window-based reference model.
module tb_trace_capture_buffer;

  localparam int DW    = 36;
  localparam int TW    = 32;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int PT    = 3;
  localparam int TO    = 20;

  logic              clk = 1'b0;
  logic              rst_n, arm, tv, trap, rdy;
  logic [DW-1:0]     td;
  logic              rd_valid;
  logic [TW+DW-1:0]  rd_data;
  logic [1:0]        state;
  logic [DL2:0]      level;
  logic              ovf, tmo;
  logic [TW-1:0]     cyc_cnt;

  trace_capture_buffer #(
    .DATA_W(DW), .DEPTH_LOG2(DL2), .TS_W(TW), .POST_TRIG(PT), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm), .trace_valid_i(tv),
    .trace_data_i(td), .trap_i(trap), .rd_ready_i(rdy),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .state_o(state),
    .level_o(level), .overflow_o(ovf), .timeout_o(tmo), .cycle_cnt_o(cyc_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: capture session described by edge index k since arm,
  // the edge at which a trap was seen and the edge at which the watchdog fired.
  logic [TW+DW-1:0] sb[$];
  bit     active = 0;
  longint k = 0, trap_k = -1, to_k = -1;
  bit     m_ovf = 0, m_to = 0;
  bit     popped = 0;
  bit     mon_en = 0;

  function automatic bit m_done();
    return (to_k >= 0) || (trap_k >= 0 && k >= trap_k + PT + 1);
  endfunction

  function automatic logic [1:0] m_state();
    if (!active) return 2'd0;
    if (m_done()) return 2'd3;
    if (trap_k >= 0) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [TW-1:0] m_cnt();
    longint mx = (64'd1 << TW) - 1;
    longint v = (k > mx) ? mx : k;
    return v[TW-1:0];
  endfunction

  function automatic logic [TW+DW-1:0] mk(input longint ts, input logic [DW-1:0] d);
    longint mx = (64'd1 << TW) - 1;
    longint t = (ts > mx) ? mx : ts;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    return {t[TW-1:0], d};
`else
    if (t < 0) return '0;
    return {{TW{1'b0}}, d};
`endif
  endfunction

  task automatic chk(input string name, input logic [TW+DW-1:0] act, input logic [TW+DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit a, input bit v, input logic [DW-1:0] d, input bit t);
    int pre;
    longint ts;
    bit in_win;
    if (!r) begin
      active = 0; k = 0; trap_k = -1; to_k = -1; m_ovf = 0; m_to = 0; popped = 0;
      sb.delete();
    end else begin
      pre = sb.size() + (popped ? 1 : 0);
      popped = 0;
      if (a) begin
        active = 1; k = 0; trap_k = -1; to_k = -1; m_ovf = 0; m_to = 0;
        sb.delete();
      end else if (active && !m_done()) begin
        ts = k;
        k++;
        in_win = (trap_k < 0) || (k <= trap_k + PT);
        if (v && in_win) begin
          if (pre >= DEPTH) m_ovf = 1;
          else sb.push_back(mk(ts, d));
        end
        if (trap_k < 0) begin
          if (t) trap_k = k;
          else if (TO != 0 && ts == TO - 1) begin to_k = k; m_to = 1; end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit a, input bit v, input logic [DW-1:0] d,
                     input bit t, input bit rd);
    rst_n = r; arm = a; tv = v; td = d; trap = t; rdy = rd;
    @(posedge clk);
    #1;
    model_edge(r, a, v, d, t);
    mon_en = 1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] w = {$urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // Monitor: compares observable state every cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("state", {{(TW+DW-2){1'b0}}, state}, {{(TW+DW-2){1'b0}}, m_state()});
      chk("level", {{(TW+DW-DL2-1){1'b0}}, level}, (TW+DW)'(sb.size()));
      chk("rd_valid", {{(TW+DW-1){1'b0}}, rd_valid}, {{(TW+DW-1){1'b0}}, sb.size() != 0});
      chk("overflow", {{(TW+DW-1){1'b0}}, ovf}, {{(TW+DW-1){1'b0}}, m_ovf});
      chk("timeout", {{(TW+DW-1){1'b0}}, tmo}, {{(TW+DW-1){1'b0}}, m_to});
      chk("cycle_cnt", {{DW{1'b0}}, cyc_cnt}, {{DW{1'b0}}, m_cnt()});
      if (rd_valid && rdy) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL pop_empty: DUT presented %0h, scoreboard empty at %0t", rd_data, $time);
        end else begin
          chk("rd_data", rd_data, sb.pop_front());
          popped = 1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; tv = 1'b0; td = '0; trap = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0, 0);
    chk("rd_data_after_reset", rd_data, '0);

    // Five words in order, then drain.
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, DW'(i), 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, '0, 0, 1);

    // Trap at timestamp 7 with trace_valid held high.
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 1, rnd_data(), i == 7, i % 2);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, '0, 0, 1);

    // Fill past capacity, then writes during pop-while-full.
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
    for (int i = 0; i < 4; i++)  cyc(1, 0, 1, rnd_data(), 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, '0, 0, 1);

    // Watchdog alone, then trap on the watchdog cycle.
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 25; i++) cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 26; i++) cyc(1, 0, 0, '0, i == 19, 0);

    // Re-arm during POST, then reset mid-capture.
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
    cyc(1, 0, 0, '0, 1, 0);
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, rnd_data(), 0, 0);
    cyc(0, 0, 1, rnd_data(), 0, 1);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, '0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 7),
          rnd_data(),
          ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 1) == 1));
    end
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, '0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Synthesizable, parametrised trace recorder for the picorv32 demo system. It generalises the bench-only trace/trap/timeout logic into RTL that can live inside the system. The block captures `trace_valid_i`/`trace_data_i` words into an on-chip FIFO, tagging each with an optional cycle timestamp. It stops after a trap plus a programmable post-trigger window, or on a watchdog timeout. Captured words drain through a valid/ready read port, e.g. to a Wishbone bridge or UART dumper.

## Interface
- `DATA_W`, 36: trace word width.
- `DEPTH_LOG2`, 10: FIFO depth is 2^DEPTH_LOG2 entries.
- `TS_W`, 32: timestamp / cycle-counter width.
- `POST_TRIG`, 10: cycles still captured after `trap_i`; 0 allowed.
- `TIMEOUT`, 1000000: cycles in ARMED before forced stop; 0 disables the watchdog.

- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_n_i` in 1: reset, synchronous and active-low.
- `arm_i` in 1: start/restart capture (level-sampled each cycle).
- `trace_valid_i` in 1: trace word present.
- `trace_data_i` in DATA_W: trace word.
- `trap_i` in 1: CPU trap.
- `rd_ready_i` in 1: consumer accepts head word.
- `rd_valid_o` out 1: FIFO non-empty.
- `rd_data_o` out TS_W+DATA_W: {timestamp, trace word} at head.
- `state_o` out 2: IDLE=0, ARMED=1, POST=2, DONE=3.
- `level_o` out DEPTH_LOG2+1: stored entries, 0..2^DEPTH_LOG2.
- `overflow_o` out 1: sticky, a word was dropped.
- `timeout_o` out 1: sticky, watchdog fired.
- `cycle_cnt_o` out TS_W: cycles since last arm, saturating.

## Operation
- IDLE: no capture. `arm_i` → ARMED.
- Entry to ARMED from any state via `arm_i`:
  - flushes the FIFO (level 0);
  - clears `cycle_cnt_o`, `overflow_o` and `timeout_o`;
  - loads the post-trigger counter with POST_TRIG.
- ARMED: capture each cycle with `trace_valid_i`=1.
  - `trap_i` → POST.
  - Else, when `cycle_cnt_o` reaches TIMEOUT-1 (TIMEOUT≠0) → DONE with `timeout_o`=1.
  - Trap and timeout in the same cycle: trap wins.
- POST: capture continues.
  - The post counter decrements each cycle; at 0 → DONE.
  - With POST_TRIG=0, POST lasts 1 cycle and captures nothing.
  - Further traps are ignored.
- DONE: no capture; readout continues. `arm_i` → ARMED.
- `arm_i` has priority over every other transition, including during ARMED/POST (restart).
- Capture word = {cycle_cnt at that cycle, `trace_data_i`}.
  - A trace word in the same cycle as the trap is captured.
- Write when full:
  - The word is dropped and `overflow_o` set.
  - Fullness is judged on the pre-cycle level, so a simultaneous pop does not make room.
- Read: first-word-fall-through.
  - `rd_valid_o` = (level≠0); `rd_data_o` is valid in the same cycle.
  - Pop on `rd_valid_o && rd_ready_i`, in any state.
  - Simultaneous accepted write and pop: level unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- `cycle_cnt_o` increments every cycle in ARMED/POST, saturates at all-ones, and holds in IDLE/DONE.

## Timing
- Reset values:
  - `state_o`=0, `level_o`=0, `rd_valid_o`=0, `overflow_o`=0, `timeout_o`=0, `cycle_cnt_o`=0.
  - `rd_data_o`=0 while empty after reset; don't-care otherwise when `rd_valid_o`=0.
- Reset mid-capture discards all contents.
- Write latency: a word written at edge N is visible on `rd_valid_o`/`rd_data_o` after edge N (1 cycle).
- `arm_i` sampled at edge N: `state_o`=1 and `cycle_cnt_o`=0 after edge N; the first capturable word is at edge N+1 and carries timestamp 0.
- `trap_i` at edge N: `state_o`=2 after N; words are captured through edge N+POST_TRIG; `state_o`=3 after edge N+POST_TRIG+1.
- Pop: `rd_data_o` advances to the next entry after the accepting edge.

## Configuration
- `TRACE_CAPTURE_TIMESTAMP_EN` defined: timestamps are stored per entry and appear in the upper TS_W bits of `rd_data_o`.
- Not defined:
  - no timestamp storage in the FIFO;
  - upper TS_W bits of `rd_data_o` tied 0;
  - `cycle_cnt_o` and the watchdog still operate.

## Test plan
- Reset, then arm; drive trace_valid with data 0x1..0x5 on consecutive cycles; no trap → 5 entries read back in order with timestamps 0..4, `level_o` returns to 0.
- Trap at timestamp 7 with POST_TRIG=3 and trace_valid held high → last captured timestamp 10, `state_o`=3 one cycle later, later trace words ignored.
- DEPTH_LOG2=2, 6 writes, no reads → `level_o`=4, `overflow_o`=1, readout returns the first 4 words only; a write during a pop-while-full is also dropped.
- TIMEOUT=20, no trap → `timeout_o`=1, `state_o`=3 after 20 armed cycles; trap on that same cycle instead → `state_o`=2, `timeout_o`=0.
- Re-arm during POST with 3 entries stored → `level_o`=0, `cycle_cnt_o`=0, `state_o`=1, sticky flags cleared; `rst_n_i` low mid-capture → all outputs at reset values next cycle.
- Build without `TRACE_CAPTURE_TIMESTAMP_EN` → upper TS_W bits of `rd_data_o` read 0, data order unchanged.
